// File: rtl/fc_mac_sequencer.sv
// Fully-connected MAC sequencer: dot product of snapshotted activations with one
// ROM weight row plus bias per output neuron, rescaled, saturated, optional ReLU.
module fc_mac_sequencer #(
  parameter int unsigned NUM_IN   = 2,
  parameter int unsigned NUM_OUT  = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned W_ADDR_W = 16,
  parameter int unsigned OUT_BASE = 0,
  parameter int unsigned RELU     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_IN*DATA_W-1:0] in_values,
  output logic [W_ADDR_W-1:0]      w_addr,
  output logic                     w_re,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     load_en,
  output logic [15:0]              load_address,
  output logic [DATA_W-1:0]        load_value,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IW = $clog2(NUM_IN + 1);
  localparam int unsigned OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned PW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_MAC, ST_WR, ST_DONE} state_t;

  state_t                    state_q;
  logic [DATA_W-1:0]         snap_q [NUM_IN];
  logic [IW-1:0]             i_q;
  logic [OW-1:0]             o_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [W_ADDR_W-1:0]       w_addr_q;
  logic                      w_re_q;
  logic                      load_en_q;
  logic [15:0]               load_address_q;
  logic [DATA_W-1:0]         load_value_q;
  logic                      busy_q;
  logic                      done_q;

  logic [DATA_W-1:0]         act;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         res;
  logic                      last_term;

  always_comb begin
    act = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (i_q == IW'(k)) act = snap_q[k];
    end
    prod      = PW'($signed(act)) * PW'($signed(w_data));
    bias_ext  = ACC_W'($signed(w_data)) <<< FRAC;
    last_term = (i_q == IW'(NUM_IN));
    acc_d     = acc_q + (last_term ? bias_ext : ACC_W'(prod));
    shifted   = acc_d >>> FRAC;
    if (shifted > SAT_MAX)      res = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_MIN) res = {1'b1, {(DATA_W-1){1'b0}}};
    else                        res = shifted[DATA_W-1:0];
    if (RELU != 0 && res[DATA_W-1]) res = '0;
  end

  // The ROM is row-major with the bias closing each row, so the read address is a
  // simple running counter instead of o*(NUM_IN+1)+i.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      for (int unsigned k = 0; k < NUM_IN; k++) snap_q[k] <= '0;
      i_q            <= '0;
      o_q            <= '0;
      acc_q          <= '0;
      w_addr_q       <= '0;
      w_re_q         <= 1'b0;
      load_en_q      <= 1'b0;
      load_address_q <= '0;
      load_value_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      w_re_q    <= 1'b0;
      load_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < NUM_IN; k++)
              snap_q[k] <= in_values[k*DATA_W +: DATA_W];
            i_q      <= '0;
            o_q      <= '0;
            acc_q    <= '0;
            w_addr_q <= '0;
            w_re_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_RD;
          end
        end
        ST_RD: state_q <= ST_MAC;
        ST_MAC: begin
          acc_q <= acc_d;
          if (!last_term) begin
            i_q      <= i_q + IW'(1);
            w_addr_q <= w_addr_q + W_ADDR_W'(1);
            w_re_q   <= 1'b1;
            state_q  <= ST_RD;
          end else begin
            load_en_q      <= 1'b1;
            load_address_q <= 16'(OUT_BASE) + 16'(o_q);
            load_value_q   <= res;
            state_q        <= ST_WR;
          end
        end
        ST_WR: begin
          if (o_q == OW'(NUM_OUT - 1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            o_q      <= o_q + OW'(1);
            i_q      <= '0;
            acc_q    <= '0;
            w_addr_q <= w_addr_q + W_ADDR_W'(1);
            w_re_q   <= 1'b1;
            state_q  <= ST_RD;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_addr       = w_addr_q;
  assign w_re         = w_re_q;
  assign load_en      = load_en_q;
  assign load_address = load_address_q;
  assign load_value   = load_value_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
